// File: rtl/ad7276_sample_ctrl.sv
// AD7276 frame controller: drives CS_n/SCLK, shifts in 16-bit frames, emits 12-bit codes on AXI-Stream.
// Define AD7276_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module ad7276_sample_ctrl #(
  parameter int DIV_WIDTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_ctrl,
  input  logic [7:0]           quiet_cycles,
  input  logic                 trig,
  input  logic                 cont_en,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overrun,
  output logic                 busy
`ifdef AD7276_OVERRUN_CNT_EN
  ,
  output logic [15:0]          overrun_cnt
`endif
);
  // Half-period counter must hold 2^(2^DIV_WIDTH - 1) - 1.
  localparam int CNT_W = 2 ** DIV_WIDTH;

  typedef enum logic [1:0] {IDLE, START, SHIFT, QUIET} state_t;

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [CNT_W-1:0]     half_cnt_reg, half_cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [7:0]           quiet_cnt_reg, quiet_cnt_next;
  logic                 sclk_reg, sclk_next;
  logic                 cs_n_reg, cs_n_next;
  logic [13:0]          shift_reg;
  logic                 shift_en;
  logic                 frame_done;
  logic                 sample_rdy_reg;
  logic [15:0]          tdata_reg;
  logic                 tvalid_reg;
  logic                 overrun_reg;
  logic                 sample_drop;

  function automatic logic [CNT_W-1:0] half_m1(input logic [DIV_WIDTH-1:0] d);
    return (CNT_W'(1) << d) - CNT_W'(1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      half_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      quiet_cnt_reg <= '0;
      sclk_reg      <= 1'b1;
      cs_n_reg      <= 1'b1;
      shift_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      half_cnt_reg  <= half_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      quiet_cnt_reg <= quiet_cnt_next;
      sclk_reg      <= sclk_next;
      cs_n_reg      <= cs_n_next;
      if (shift_en)
        shift_reg <= {shift_reg[12:0], adc_sdata};
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    half_cnt_next  = half_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    quiet_cnt_next = quiet_cnt_reg;
    sclk_next      = sclk_reg;
    shift_en       = 1'b0;
    frame_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trig || cont_en) begin
          state_next    = START;
          div_next      = div_ctrl;
          half_cnt_next = half_m1(div_ctrl);
          sclk_next     = 1'b1;
        end
      end
      START: begin
        if (half_cnt_reg == '0) begin
          state_next    = SHIFT;
          sclk_next     = 1'b0;
          half_cnt_next = half_m1(div_reg);
          bit_cnt_next  = '0;
        end else begin
          half_cnt_next = half_cnt_reg - CNT_W'(1);
        end
      end
      SHIFT: begin
        if (half_cnt_reg != '0) begin
          half_cnt_next = half_cnt_reg - CNT_W'(1);
        end else if (!sclk_reg) begin
          // Data is captured on the cycle that raises SCLK.
          sclk_next     = 1'b1;
          shift_en      = 1'b1;
          half_cnt_next = half_m1(div_reg);
        end else if (bit_cnt_reg == 4'd15) begin
          state_next     = QUIET;
          frame_done     = 1'b1;
          quiet_cnt_next = (quiet_cycles == 8'd0) ? 8'd0 : quiet_cycles - 8'd1;
        end else begin
          sclk_next     = 1'b0;
          bit_cnt_next  = bit_cnt_reg + 4'd1;
          half_cnt_next = half_m1(div_reg);
        end
      end
      QUIET: begin
        if (quiet_cnt_reg != 8'd0) begin
          quiet_cnt_next = quiet_cnt_reg - 8'd1;
        end else if (cont_en) begin
          state_next    = START;
          div_next      = div_ctrl;
          half_cnt_next = half_m1(div_ctrl);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cs_n_next = !((state_next == START) || (state_next == SHIFT));
    busy      = (state_reg != IDLE);
  end

  // A finished sample is offered one cycle after QUIET entry; a still-pending output wins.
  assign sample_drop = sample_rdy_reg && tvalid_reg && !m_axis_tready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sample_rdy_reg <= 1'b0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sample_rdy_reg <= frame_done;
      if (sample_rdy_reg && !sample_drop) begin
        tdata_reg  <= {4'b0000, shift_reg[13:2]};
        tvalid_reg <= 1'b1;
      end else if (sample_drop) begin
        overrun_reg <= 1'b1;
      end else if (tvalid_reg && m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

`ifdef AD7276_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_reg;

  always_ff @(posedge clk_in) begin
    if (rst)
      overrun_cnt_reg <= '0;
    else if (sample_drop && (overrun_cnt_reg != 16'hFFFF))
      overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
  end

  assign overrun_cnt = overrun_cnt_reg;
`endif

  assign adc_cs_n      = cs_n_reg;
  assign adc_sclk      = sclk_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign overrun       = overrun_reg;
endmodule

// File: tb/tb_ad7276_sample_ctrl.sv
// Scoreboard bench for ad7276_sample_ctrl: ADC word model, protocol timing monitor and AXI-Stream checker.
module tb_ad7276_sample_ctrl;
  localparam int DW = 2;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] div_ctrl = '0;
  logic [7:0]    quiet_cycles = 8'd4;
  logic          trig = 1'b0;
  logic          cont_en = 1'b0;
  logic          adc_sdata = 1'b0;
  logic          m_axis_tready = 1'b1;
  logic          adc_cs_n, adc_sclk, m_axis_tvalid, overrun, busy;
  logic [15:0]   m_axis_tdata;
`ifdef AD7276_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  ad7276_sample_ctrl #(.DIV_WIDTH(DW)) dut (
    .clk_in(clk_in), .rst(rst), .div_ctrl(div_ctrl), .quiet_cycles(quiet_cycles),
    .trig(trig), .cont_en(cont_en), .adc_sdata(adc_sdata), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .overrun(overrun), .busy(busy)
`ifdef AD7276_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC model: new random (or forced) word per CS_n fall, MSB first, next bit after each SCLK rise.
  logic [15:0] adc_word = '0;
  int          adc_idx = 16;
  logic        adc_prev_cs = 1'b1, adc_prev_sclk = 1'b1;
  logic        force_en = 1'b0;
  logic [15:0] force_word = '0;
  logic [15:0] word_q[$];

  always @(posedge clk_in) begin
    #1;
    if (adc_prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      adc_word = force_en ? force_word : 16'($urandom);
      word_q.push_back(adc_word);
      adc_idx = 0;
    end else if (adc_cs_n === 1'b0 && adc_prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
      adc_idx++;
    end
    adc_prev_cs   = adc_cs_n;
    adc_prev_sclk = adc_sclk;
    adc_sdata     = (adc_idx < 16) ? adc_word[15 - adc_idx] : 1'b0;
  end

  // Monitor + reference model: frame timing, sample acceptance/drop, scoreboard of expected tdata.
  logic          mon_en = 1'b0;
  logic          in_frame = 1'b0;
  logic          prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [DW-1:0] prev_div = '0;
  int            half_cur = 1, run_len = 0, low_len = 0, rises = 0, gap_len = 0;
  int            falls = 0, frames_done = 0, xfers = 0, exp_gap = -1;
  logic          model_valid = 1'b0, model_ovr = 1'b0;
  int            model_cnt = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   last_xfer = '0;

  always @(negedge clk_in) begin
    logic xfer, load, drop;
    logic [15:0] w, e;
    if (mon_en) begin
      check("tvalid", m_axis_tvalid, model_valid);
      check("overrun", overrun, model_ovr);
`ifdef AD7276_OVERRUN_CNT_EN
      check("overrun_cnt", overrun_cnt, model_cnt);
`endif
      if (adc_cs_n === 1'b0) check("busy_in_frame", busy, 1);
      xfer = model_valid && m_axis_tready;
      load = 1'b0;
      drop = 1'b0;
      if (adc_cs_n === 1'b0 && prev_cs) begin
        falls++;
        in_frame = 1'b1;
        half_cur = 1 << prev_div;
        run_len  = 1;
        low_len  = 1;
        rises    = 0;
        check("start_sclk_high", adc_sclk, 1);
        if (exp_gap >= 0) check("cs_gap", gap_len, exp_gap);
      end else if (adc_cs_n === 1'b0 && in_frame) begin
        low_len++;
        if (adc_sclk === prev_sclk) run_len++;
        else begin
          check("sclk_half", run_len, half_cur);
          run_len = 1;
          if (adc_sclk) rises++;
        end
      end else if (adc_cs_n === 1'b1 && !prev_cs && in_frame) begin
        in_frame = 1'b0;
        gap_len  = 1;
        check("sclk_half", run_len, half_cur);
        check("cs_low_len", low_len, 33 * half_cur);
        check("sclk_rises", rises, 16);
        load = 1'b1;
      end else if (adc_cs_n === 1'b1) begin
        gap_len++;
      end

      if (xfer) begin
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e);
          last_xfer = m_axis_tdata;
          xfers++;
          $display("xfer %0d: tdata=%h expected=%h", xfers, m_axis_tdata, e);
        end
      end
      if (load) begin
        frames_done++;
        check("word_q_has_entry", word_q.size() != 0, 1);
        w = (word_q.size() != 0) ? word_q.pop_front() : 16'h0000;
        if (model_valid && !m_axis_tready) begin
          drop = 1'b1;
          model_ovr = 1'b1;
          if (model_cnt < 65535) model_cnt++;
          $display("frame %0d: word=%h dropped (output pending)", frames_done, w);
        end else begin
          exp_q.push_back({4'b0000, w[13:2]});
          $display("frame %0d: word=%h queued code=%h", frames_done, w, {4'b0000, w[13:2]});
        end
      end
      if (load && !drop) model_valid = 1'b1;
      else if (xfer) model_valid = 1'b0;
      if (rst) begin
        model_valid = 1'b0;
        model_ovr   = 1'b0;
        model_cnt   = 0;
        exp_q.delete();
        word_q.delete();
        in_frame = 1'b0;
        gap_len  = 0;
      end
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
    prev_div  = div_ctrl;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_trig();
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle(input logic need_tv_low, input int budget);
    int n = 0;
    tick();
    while ((busy || (need_tv_low && m_axis_tvalid)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout_idle", n, 0);
    repeat (2) tick();
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n = 0;
    while (!(in_frame && rises >= target) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout_rises", n, 0);
  endtask

  task automatic wait_falls(input int target, input int budget);
    int n = 0;
    while (falls < target && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout_falls", n, 0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout_frames", n, 0);
  endtask

  initial begin
    int f0;
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // Fixed frame 16'h1ABC at the fastest SCLK.
    div_ctrl = 0; quiet_cycles = 8'd4; m_axis_tready = 1'b1;
    force_en = 1'b1; force_word = 16'h1ABC;
    pulse_trig();
    wait_idle(1'b1, 2000);
    check("code_1abc", last_xfer, 16'h06AF);
    force_en = 1'b0;

    // Slowest SCLK used here: 4-cycle half period.
    div_ctrl = 2; quiet_cycles = 8'd3;
    pulse_trig();
    wait_idle(1'b1, 2000);

    // Randomized runs: varying divider, quiet time, backpressure, stray triggers.
    for (int it = 0; it < 10; it++) begin
      int ncyc;
      div_ctrl     = DW'($urandom_range(0, 3));
      quiet_cycles = 8'($urandom_range(0, 6));
      cont_en      = ($urandom_range(0, 2) == 0);
      ncyc         = $urandom_range(60, 400);
      pulse_trig();
      for (int c = 0; c < ncyc; c++) begin
        tick();
        m_axis_tready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) div_ctrl = DW'($urandom_range(0, 3));
        trig = ($urandom_range(0, 31) == 0);
      end
      trig = 1'b0; cont_en = 1'b0; m_axis_tready = 1'b1;
      wait_idle(1'b1, 3000);
    end

    // Back-to-back frames with free-flowing output: exact 10-cycle gaps, no overrun.
    rst = 1'b1; tick(); rst = 1'b0;
    div_ctrl = 0; quiet_cycles = 8'd10; m_axis_tready = 1'b1;
    f0 = frames_done;
    cont_en = 1'b1;
    wait_falls(falls + 1, 100);
    exp_gap = 10;
    wait_frames(f0 + 3, 1000);
    exp_gap = -1;
    cont_en = 1'b0;
    wait_idle(1'b1, 2000);
    check("cont_no_overrun", overrun, 0);

    // Back-to-back with a stalled sink: first sample held, second dropped.
    div_ctrl = 0; quiet_cycles = 8'd2; m_axis_tready = 1'b0;
    f0 = falls;
    cont_en = 1'b1;
    wait_falls(f0 + 2, 500);
    cont_en = 1'b0;
    wait_idle(1'b0, 2000);
    check("stall_overrun", overrun, 1);
    check("stall_tvalid_held", m_axis_tvalid, 1);
`ifdef AD7276_OVERRUN_CNT_EN
    check("stall_overrun_cnt", overrun_cnt, 1);
`endif
    m_axis_tready = 1'b1;
    wait_idle(1'b1, 100);
    check("overrun_sticky", overrun, 1);

    // Reset after the 7th SCLK rise aborts the frame; next trigger runs cleanly.
    div_ctrl = 1; quiet_cycles = 8'd3;
    pulse_trig();
    wait_rises(7, 500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cs_n", adc_cs_n, 1);
    check("abort_sclk", adc_sclk, 1);
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    f0 = frames_done;
    pulse_trig();
    wait_idle(1'b1, 2000);
    check("after_abort_frames", frames_done - f0, 1);

    // Trigger during SHIFT is ignored.
    div_ctrl = 0; quiet_cycles = 8'd2;
    f0 = frames_done;
    pulse_trig();
    wait_rises(5, 500);
    pulse_trig();
    wait_idle(1'b1, 2000);
    check("trig_in_shift_frames", frames_done - f0, 1);
    check("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
